// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweeper comparing a canonical
// and a reduced logic function, counting mismatches and minterms.
module truth_table_sweeper #(
  parameter int K      = 5,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [K-1:0] vec_out,
  input  logic         ref_in,
  input  logic         red_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [K:0]   mismatch_count,
  output logic [K:0]   ones_count,
  output logic         first_fail_vld,
  output logic [K-1:0] first_fail_idx
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  vec_q, vec_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [K:0]    mism_q, mism_d;
  logic [K:0]    ones_q, ones_d;
  logic          ffv_q, ffv_d;
  logic [K-1:0]  ffi_q, ffi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mism_q  <= '0;
      ones_q  <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
      ones_q  <= ones_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign miss = ref_in ^ red_in;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mism_d  = mism_q;
    ones_d  = ones_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          vec_d   = '0;
          mism_d  = '0;
          ones_d  = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_APPLY: begin
        cnt_d   = SW'(SETTLE);
        state_d = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
      end

      // Leave on the edge where the counter hits zero: SETTLE cycles in total.
      ST_SETTLE: begin
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        ones_d = ones_q + {{K{1'b0}}, ref_in};
        mism_d = mism_q + {{K{1'b0}}, miss};
        if (miss && !ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = vec_q;
        end
        if (vec_q == {K{1'b1}}) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Judged on the count including this final sample.
          pass_d  = (mism_d == '0);
        end else begin
          vec_d   = vec_q + K'(1);
          state_d = ST_APPLY;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign vec_out        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_count = mism_q;
  assign ones_count     = ones_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - table-driven bench for truth_table_sweeper
// with SETTLE=2 and SETTLE=0 instances.
module tb_truth_table_sweeper;

  localparam int K = 5;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  int   mode;
  int   cur;
  int   checks = 0;
  int   errors = 0;

  logic [K-1:0] vec0, vec1, ffi0, ffi1;
  logic [K:0]   mism0, mism1, ones0, ones1;
  logic         busy0, busy1, done0, done1, pass0, pass1, ffv0, ffv1;
  logic         ref0, red0, ref1, red1;

  logic [K-1:0] s_vec, s_ffi;
  logic [K:0]   s_mism, s_ones;
  logic         s_busy, s_done, s_pass, s_ffv;

  always #5 clk = ~clk;

  // Function-under-test model: 0 equal parity, 1 parity with faults at 13/22, 2 ref=1 red=0.
  function automatic logic f_ref(input int m, input logic [K-1:0] v);
    return (m == 2) ? 1'b1 : ^v;
  endfunction

  function automatic logic f_red(input int m, input logic [K-1:0] v);
    if (m == 2) return 1'b0;
    return (^v) ^ ((m == 1) && (v == 5'd13 || v == 5'd22));
  endfunction

  assign ref0 = f_ref(mode, vec0);
  assign red0 = f_red(mode, vec0);
  assign ref1 = f_ref(mode, vec1);
  assign red1 = f_red(mode, vec1);

  truth_table_sweeper #(.K(K), .SETTLE(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .vec_out(vec0),
    .ref_in(ref0), .red_in(red0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch_count(mism0), .ones_count(ones0),
    .first_fail_vld(ffv0), .first_fail_idx(ffi0)
  );

  truth_table_sweeper #(.K(K), .SETTLE(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .vec_out(vec1),
    .ref_in(ref1), .red_in(red1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_count(mism1), .ones_count(ones1),
    .first_fail_vld(ffv1), .first_fail_idx(ffi1)
  );

  always_comb begin
    if (cur == 1) begin
      s_vec = vec1; s_ffi = ffi1; s_mism = mism1; s_ones = ones1;
      s_busy = busy1; s_done = done1; s_pass = pass1; s_ffv = ffv1;
    end else begin
      s_vec = vec0; s_ffi = ffi0; s_mism = mism0; s_ones = ones0;
      s_busy = busy0; s_done = done0; s_pass = pass0; s_ffv = ffv0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v;
    else          start0 = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " vec0"}, int'(vec0), 0);
    chk({tag, " busy0"}, int'(busy0), 0);
    chk({tag, " done0"}, int'(done0), 0);
    chk({tag, " pass0"}, int'(pass0), 0);
    chk({tag, " mism0"}, int'(mism0), 0);
    chk({tag, " ones0"}, int'(ones0), 0);
    chk({tag, " ffv0"}, int'(ffv0), 0);
    chk({tag, " ffi0"}, int'(ffi0), 0);
    chk({tag, " busy1"}, int'(busy1), 0);
    chk({tag, " done1"}, int'(done1), 0);
    chk({tag, " mism1"}, int'(mism1), 0);
  endtask

  typedef struct {
    string name;
    int    sel;
    int    mode;
    int    ign_at;
    int    edges;
    int    mism;
    int    ones;
    int    ffv;
    int    ffi;
    int    pass;
  } vec_t;

  task automatic run_sweep(input vec_t t);
    int  n;
    bit  pulsed;
    mode = t.mode;
    cur  = t.sel;
    set_start(t.sel, 1'b1);
    @(posedge clk); #1;
    set_start(t.sel, 1'b0);
    chk({t.name, " start busy"}, int'(s_busy), 1);
    chk({t.name, " start done"}, int'(s_done), 0);
    chk({t.name, " start pass"}, int'(s_pass), 0);
    chk({t.name, " start vec"}, int'(s_vec), 0);
    chk({t.name, " start mism"}, int'(s_mism), 0);
    chk({t.name, " start ones"}, int'(s_ones), 0);
    chk({t.name, " start ffv"}, int'(s_ffv), 0);
    n = 0;
    pulsed = 0;
    while (!s_done && n < 1000) begin
      if (t.ign_at >= 0 && !pulsed && s_busy && int'(s_vec) == t.ign_at) begin
        set_start(t.sel, 1'b1);
        pulsed = 1;
      end
      @(posedge clk); #1;
      set_start(t.sel, 1'b0);
      n++;
    end
    chk({t.name, " done latency"}, n, t.edges);
    chk({t.name, " busy"}, int'(s_busy), 0);
    chk({t.name, " mismatch_count"}, int'(s_mism), t.mism);
    chk({t.name, " ones_count"}, int'(s_ones), t.ones);
    chk({t.name, " first_fail_vld"}, int'(s_ffv), t.ffv);
    chk({t.name, " first_fail_idx"}, int'(s_ffi), t.ffi);
    chk({t.name, " pass"}, int'(s_pass), t.pass);
    @(posedge clk); #1;
    chk({t.name, " done held"}, int'(s_done), 1);
  endtask

  vec_t tbl[6];

  initial begin
    int n;
    tbl[0] = '{"clean",     0, 0, -1, 128,  0, 16, 0,  0, 1};
    tbl[1] = '{"two_fault", 0, 1, -1, 128,  2, 16, 1, 13, 0};
    tbl[2] = '{"ign_start", 0, 0,  7, 128,  0, 16, 0,  0, 1};
    tbl[3] = '{"restart",   0, 0, -1, 128,  0, 16, 0,  0, 1};
    tbl[4] = '{"s0_allbad", 1, 2, -1,  64, 32, 32, 1,  0, 0};
    tbl[5] = '{"s0_clean",  1, 0, -1,  64,  0, 16, 0,  0, 1};

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 0; cur = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("idle");

    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i]);
    end

    // Mid-clock reset while dut0 has reached vector 10, then a full fresh sweep.
    mode = 0; cur = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (vec0 != 5'd10 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach vec 10", int'(vec0), 10);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("post_reset");
    run_sweep(tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
